nnrv_if_pq: RTL and testbench

Parametrised instruction-fetch unit with prefetch queue and redirect support for the nnrv core. It drives a synchronous one-cycle-latency instruction ROM. Fetched words are buffered with their PC in a QDEPTH-entry FIFO and handed to decode over a valid/ready handshake. It sits between the instruction ROM and the decode stage, and it accepts branch/jump redirects from the execute stage.

---
 rtl/nnrv_if_pq.sv | 108 ++++++++++
 tb/tb_nnrv_if_pq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nnrv_if_pq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nnrv_if_pq : instruction fetch with prefetch queue and redirect flush    |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module nnrv_if_pq #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int RESET_PC    = 0,
    parameter int QDEPTH      = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic                   o_rd_en,
    output logic                   o_ce,
    input  logic [INSTR_WIDTH-1:0] i_rom_instr,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    output logic                   o_id_valid,
    output logic [INSTR_WIDTH-1:0] o_id_instr,
    output logic [ADDR_WIDTH-1:0]  o_id_pc,
    input  logic                   i_id_ready
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic                   inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0]  ifpc_q, ifpc_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [INSTR_WIDTH-1:0] instr_q [QDEPTH];
    logic [ADDR_WIDTH-1:0]  pcs_q   [QDEPTH];

    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [CW:0]   w_occ;

    assign w_pop  = (count_q != '0) && i_id_ready;
    assign w_push = inflight_q && !i_redirect;

    // Slots already promised to the queue plus the in-flight word, net of a pop this cycle.
    assign w_occ   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, w_pop};
    assign w_issue = i_rst_n && !i_redirect && (w_occ < (CW+1)'(QDEPTH));

    assign o_pc       = fetch_pc_q;
    assign o_rd_en    = w_issue;
    assign o_ce       = w_issue;
    assign o_id_valid = (count_q != '0);
    assign o_id_instr = instr_q[rd_ptr_q];
    assign o_id_pc    = pcs_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = 1'b0;
        ifpc_d     = ifpc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (i_redirect) begin
            fetch_pc_d = i_redirect_pc & ~ADDR_WIDTH'(3);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (w_issue) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
                inflight_d = 1'b1;
                ifpc_d     = fetch_pc_q;
            end
            count_d  = count_q + CW'(w_push) - CW'(w_pop);
            rd_ptr_d = rd_ptr_q + PW'(w_pop);
            wr_ptr_d = wr_ptr_q + PW'(w_push);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q <= ADDR_WIDTH'(RESET_PC);
            inflight_q <= 1'b0;
            ifpc_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                instr_q[i] <= '0;
                pcs_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            ifpc_q     <= ifpc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (w_push) begin
                instr_q[wr_ptr_q] <= i_rom_instr;
                pcs_q[wr_ptr_q]   <= ifpc_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nnrv_if_pq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nnrv_if_pq : bench for nnrv_if_pq against a queue-level fetch model   |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_nnrv_if_pq;

    localparam int QD = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  o_pc;
    logic        o_rd_en;
    logic        o_ce;
    logic [31:0] i_rom_instr = '0;
    logic        i_redirect = 1'b0;
    logic [7:0]  i_redirect_pc = '0;
    logic        o_id_valid;
    logic [31:0] o_id_instr;
    logic [7:0]  o_id_pc;
    logic        i_id_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic [7:0] got[$];
    logic [7:0] fpc;
    bit         pend;
    logic [7:0] ppc;

    nnrv_if_pq #(
        .INSTR_WIDTH(32), .ADDR_WIDTH(8), .RESET_PC(0), .QDEPTH(QD)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .o_pc(o_pc), .o_rd_en(o_rd_en),
        .o_ce(o_ce), .i_rom_instr(i_rom_instr), .i_redirect(i_redirect),
        .i_redirect_pc(i_redirect_pc), .o_id_valid(o_id_valid),
        .o_id_instr(o_id_instr), .o_id_pc(o_id_pc), .i_id_ready(i_id_ready)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] romf(input logic [7:0] a);
        return {8'hA5, a ^ 8'h3C, ~a, a};
    endfunction

    // Synchronous ROM: data for the address sampled at an issuing edge appears after it.
    always @(posedge i_clk) if (o_rd_en) i_rom_instr <= romf(o_pc);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        mq.delete();
        fpc  = 8'h00;
        pend = 1'b0;
        ppc  = 8'h00;
    endtask

    function automatic logic [7:0] gotv(input int i);
        if (got.size() > i) return got[i];
        return 8'hxx;
    endfunction

    task automatic step(input bit rdy, input bit rd, input logic [7:0] rpc);
        bit ev, ei, pop;
        int occ;
        i_id_ready    = rdy;
        i_redirect    = rd;
        i_redirect_pc = rpc;
        #1;
        ev  = (mq.size() != 0);
        pop = ev && rdy;
        occ = mq.size() + (pend ? 1 : 0) - (pop ? 1 : 0);
        ei  = !rd && (occ < QD);
        check("rd_en", {31'd0, o_rd_en}, {31'd0, ei});
        check("ce", {31'd0, o_ce}, {31'd0, ei});
        check("pc", {24'd0, o_pc}, {24'd0, fpc});
        check("id_valid", {31'd0, o_id_valid}, {31'd0, ev});
        if (ev) begin
            check("id_pc", {24'd0, o_id_pc}, {24'd0, mq[0]});
            check("id_instr", o_id_instr, romf(mq[0]));
        end
        if (o_id_valid && i_id_ready) got.push_back(o_id_pc);
        @(posedge i_clk);
        if (pop) void'(mq.pop_front());
        if (rd) begin
            mq.delete();
            pend = 1'b0;
            fpc  = rpc & 8'hFC;
        end else begin
            if (pend) mq.push_back(ppc);
            if (ei) begin
                pend = 1'b1;
                ppc  = fpc;
                fpc  = fpc + 8'd4;
            end else begin
                pend = 1'b0;
            end
        end
        @(negedge i_clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge i_clk);
        #1;
        check("rst_rd_en", {31'd0, o_rd_en}, 32'd0);
        check("rst_valid", {31'd0, o_id_valid}, 32'd0);
        check("rst_id_pc", {24'd0, o_id_pc}, 32'd0);
        check("rst_id_instr", o_id_instr, 32'd0);
        check("rst_pc", {24'd0, o_pc}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        mreset();

        // Streaming from reset with decode always ready
        got.delete();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        #1 check("valid_after_2", {31'd0, o_id_valid}, 32'd1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) check("stream_pc", {24'd0, gotv(i)}, 4 * i);

        // Back-pressure from a fresh reset
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        mreset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00);
        #1;
        check("bp_rd_en", {31'd0, o_rd_en}, 32'd0);
        check("bp_pc_hold", {24'd0, o_pc}, 32'h10);
        check("bp_head", {24'd0, o_id_pc}, 32'h00);
        got.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) check("bp_order", {24'd0, gotv(i)}, 4 * i);

        // Redirect with a pop and a would-be issue on the same edge
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h41);
        i_redirect = 1'b0;
        #1;
        check("redir_pc", {24'd0, o_pc}, 32'h40);
        check("redir_empty", {31'd0, o_id_valid}, 32'd0);
        got.delete();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h00);
        check("redir_first", {24'd0, gotv(0)}, 32'h40);
        check("redir_second", {24'd0, gotv(1)}, 32'h44);

        // Address wrap-around
        step(1'b1, 1'b1, 8'hF8);
        got.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00);
        check("wrap0", {24'd0, gotv(0)}, 32'hF8);
        check("wrap1", {24'd0, gotv(1)}, 32'hFC);
        check("wrap2", {24'd0, gotv(2)}, 32'h00);
        check("wrap3", {24'd0, gotv(3)}, 32'h04);

        // Random traffic with occasional redirects
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 8'($urandom));

        // Asynchronous reset pulse between edges
        #3 i_rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, o_id_valid}, 32'd0);
        check("arst_rd_en", {31'd0, o_rd_en}, 32'd0);
        check("arst_id_pc", {24'd0, o_id_pc}, 32'd0);
        check("arst_pc", {24'd0, o_pc}, 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        #3 i_rst_n = 1'b1;
        mreset();
        got.delete();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h00);
        check("arst_restart", {24'd0, gotv(0)}, 32'h00);
        for (int i = 0; i < 100; i++)
            step($urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0, 8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
